// File: rtl/shift_unit_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_unit_seq_if
// Brief    : Request/response bundle between the execute stage and the
//            multi-cycle shift unit (valid/ready on both sides).
// Revision : 1.0
// ============================================================================
interface shift_unit_seq_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [6:0]      opcode;
  logic [2:0]      func3;
  logic [6:0]      func7;
  logic [11:0]     imm;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            illegal;

  modport master (
    output in_valid, op1, op2, opcode, func3, func7, imm, out_ready,
    input  in_ready, out_valid, result, illegal
  );

  modport slave (
    input  in_valid, op1, op2, opcode, func3, func7, imm, out_ready,
    output in_ready, out_valid, result, illegal
  );
endinterface
`default_nettype wire

// File: rtl/shift_unit_seq.sv
`default_nettype none
// ============================================================================
// Module   : shift_unit_seq
// Brief    : Multi-cycle SLL/SRL/SRA(+I) unit shifting STEP bits per cycle.
//            Define SHIFT_ROTATE_EN to also decode ROL/ROR/RORI.
// Revision : 1.0
// ============================================================================
module shift_unit_seq #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  shift_unit_seq_if.slave bus
);
  localparam int unsigned SHAMT_W = $clog2(XLEN);
  localparam int unsigned CNT_W   = SHAMT_W + 1;
  localparam int unsigned IMMH_W  = 12 - SHAMT_W;

  localparam logic [6:0]        c_opc_r     = 7'b0110011;
  localparam logic [6:0]        c_opc_i     = 7'b0010011;
  localparam logic [2:0]        c_f3_left   = 3'b001;
  localparam logic [2:0]        c_f3_right  = 3'b101;
  localparam logic [6:0]        c_f7_base   = 7'b0000000;
  localparam logic [6:0]        c_f7_alt    = 7'b0100000;
  localparam logic [IMMH_W-1:0] c_immh_srai = IMMH_W'(1) << (10 - SHAMT_W);
  localparam logic [CNT_W-1:0]  c_step      = CNT_W'(STEP);
`ifdef SHIFT_ROTATE_EN
  localparam logic [6:0]        c_f7_rot    = 7'b0110000;
  localparam logic [IMMH_W-1:0] c_immh_rori = IMMH_W'(3) << (9 - SHAMT_W);
  localparam logic [CNT_W-1:0]  c_xlen      = CNT_W'(XLEN);
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    MODE_SLL = 3'd0,
    MODE_SRL = 3'd1,
    MODE_SRA = 3'd2,
    MODE_ROL = 3'd3,
    MODE_ROR = 3'd4
  } mode_t;

  state_t               state_q;
  mode_t                mode_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 illegal_q;
  logic [XLEN-1:0]      result_q;
  logic [XLEN-1:0]      data_q;
  logic [SHAMT_W-1:0]   rem_q;

  mode_t                dec_mode_d;
  logic                 dec_illegal_d;
  logic [SHAMT_W-1:0]   dec_shamt_d;
  logic [IMMH_W-1:0]    imm_hi;
  logic [CNT_W-1:0]     rem_ext;
  logic [CNT_W-1:0]     n_d;
  logic [SHAMT_W-1:0]   rem_d;
  logic [XLEN-1:0]      shift_d;
  logic                 op2_hi_unused;

  // Shift amounts wrap modulo XLEN, so the upper rs2 bits never matter.
  assign op2_hi_unused = ^bus.op2[XLEN-1:SHAMT_W];

  always_comb begin
    dec_mode_d    = MODE_SLL;
    dec_illegal_d = 1'b1;
    dec_shamt_d   = '0;
    imm_hi        = bus.imm[11:SHAMT_W];
    if (bus.opcode == c_opc_r) begin
      dec_shamt_d = bus.op2[SHAMT_W-1:0];
      if (bus.func7 == c_f7_base && bus.func3 == c_f3_left) begin
        dec_mode_d = MODE_SLL; dec_illegal_d = 1'b0;
      end else if (bus.func7 == c_f7_base && bus.func3 == c_f3_right) begin
        dec_mode_d = MODE_SRL; dec_illegal_d = 1'b0;
      end else if (bus.func7 == c_f7_alt && bus.func3 == c_f3_right) begin
        dec_mode_d = MODE_SRA; dec_illegal_d = 1'b0;
`ifdef SHIFT_ROTATE_EN
      end else if (bus.func7 == c_f7_rot && bus.func3 == c_f3_left) begin
        dec_mode_d = MODE_ROL; dec_illegal_d = 1'b0;
      end else if (bus.func7 == c_f7_rot && bus.func3 == c_f3_right) begin
        dec_mode_d = MODE_ROR; dec_illegal_d = 1'b0;
`endif
      end
    end else if (bus.opcode == c_opc_i) begin
      dec_shamt_d = bus.imm[SHAMT_W-1:0];
      if (imm_hi == '0 && bus.func3 == c_f3_left) begin
        dec_mode_d = MODE_SLL; dec_illegal_d = 1'b0;
      end else if (imm_hi == '0 && bus.func3 == c_f3_right) begin
        dec_mode_d = MODE_SRL; dec_illegal_d = 1'b0;
      end else if (imm_hi == c_immh_srai && bus.func3 == c_f3_right) begin
        dec_mode_d = MODE_SRA; dec_illegal_d = 1'b0;
`ifdef SHIFT_ROTATE_EN
      end else if (imm_hi == c_immh_rori && bus.func3 == c_f3_right) begin
        dec_mode_d = MODE_ROR; dec_illegal_d = 1'b0;
`endif
      end
    end
  end

  // One SHIFT step moves min(rem, STEP) positions; rem is nonzero in SHIFT.
  always_comb begin
    rem_ext = {1'b0, rem_q};
    n_d     = (rem_ext < c_step) ? rem_ext : c_step;
    rem_d   = rem_q - n_d[SHAMT_W-1:0];
    case (mode_q)
      MODE_SRL: shift_d = data_q >> n_d;
      MODE_SRA: shift_d = $signed(data_q) >>> n_d;
`ifdef SHIFT_ROTATE_EN
      MODE_ROL: shift_d = (data_q << n_d) | (data_q >> (c_xlen - n_d));
      MODE_ROR: shift_d = (data_q >> n_d) | (data_q << (c_xlen - n_d));
`endif
      default:  shift_d = data_q << n_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_SLL;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      result_q    <= '0;
      data_q      <= '0;
      rem_q       <= '0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      rem_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            data_q     <= bus.op1;
            mode_q     <= dec_mode_d;
            illegal_q  <= dec_illegal_d;
            in_ready_q <= 1'b0;
            if (dec_illegal_d || dec_shamt_d == '0) begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
              rem_q       <= '0;
              result_q    <= dec_illegal_d ? '0 : bus.op1;
            end else begin
              state_q <= ST_SHIFT;
              rem_q   <= dec_shamt_d;
            end
          end
        end
        ST_SHIFT: begin
          data_q <= shift_d;
          rem_q  <= rem_d;
          if (rem_d == '0) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            result_q    <= shift_d;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_unit_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_unit_seq
// Brief    : Directed bench driving a STEP=1 and a STEP=4 instance in lockstep.
// Revision : 1.0
// ============================================================================
module tb_shift_unit_seq;
  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] op1, op2;
  logic [6:0]  opcode, func7;
  logic [2:0]  func3;
  logic [11:0] imm;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  shift_unit_seq_if #(.XLEN(32)) if1 ();
  shift_unit_seq_if #(.XLEN(32)) if4 ();

  assign if1.in_valid = in_valid;  assign if4.in_valid = in_valid;
  assign if1.op1 = op1;            assign if4.op1 = op1;
  assign if1.op2 = op2;            assign if4.op2 = op2;
  assign if1.opcode = opcode;      assign if4.opcode = opcode;
  assign if1.func3 = func3;        assign if4.func3 = func3;
  assign if1.func7 = func7;        assign if4.func7 = func7;
  assign if1.imm = imm;            assign if4.imm = imm;
  assign if1.out_ready = out_ready; assign if4.out_ready = out_ready;

  shift_unit_seq #(.XLEN(32), .STEP(1)) u_dut1 (.clk(clk), .rst(rst), .flush(flush), .bus(if1.slave));
  shift_unit_seq #(.XLEN(32), .STEP(4)) u_dut4 (.clk(clk), .rst(rst), .flush(flush), .bus(if4.slave));

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] im;
    logic [31:0] res;
    logic        ill;
    int          lat1;
    int          lat4;
  } vec_t;

  // Issues one request, records result/illegal and accept-to-valid latency
  // (accepting edge counts as 1) for both instances, then completes the handshake.
  task automatic do_op(input logic [31:0] a, b, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [11:0] im,
                       output logic [31:0] r1, r4, output logic i1, i4, output int l1, l4);
    @(negedge clk);
    op1 = a; op2 = b; opcode = opc; func3 = f3; func7 = f7; imm = im; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    l1 = -1; l4 = -1; r1 = '0; r4 = '0; i1 = 1'b0; i4 = 1'b0;
    for (int cnt = 1; cnt <= 100; cnt++) begin
      if (l1 < 0 && if1.out_valid === 1'b1) begin l1 = cnt; r1 = if1.result; i1 = if1.illegal; end
      if (l4 < 0 && if4.out_valid === 1'b1) begin l4 = cnt; r4 = if4.result; i4 = if4.illegal; end
      if (l1 >= 0 && l4 >= 0) break;
      @(posedge clk); #1;
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op1 = '0; op2 = '0; opcode = '0; func3 = '0; func7 = '0; imm = '0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    n_tests++; if (if1.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_s1: got %b want 1", if1.in_ready); end
    n_tests++; if (if4.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_s4: got %b want 1", if4.in_ready); end
    n_tests++; if (if1.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid_s1: got %b want 0", if1.out_valid); end
    n_tests++; if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid_s4: got %b want 0", if4.out_valid); end
    n_tests++; if (if1.result !== 32'h0) begin n_fail++; $display("FAIL reset_result_s1: got %h want 00000000", if1.result); end
    n_tests++; if (if4.result !== 32'h0) begin n_fail++; $display("FAIL reset_result_s4: got %h want 00000000", if4.result); end
    n_tests++; if (if1.illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal_s1: got %b want 0", if1.illegal); end
    n_tests++; if (if4.illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal_s4: got %b want 0", if4.illegal); end
  endtask

  task automatic test_shift_modes();
    vec_t v[7];
    logic [31:0] r1, r4; logic i1, i4; int l1, l4;
    v[0] = '{"sll31",   32'h00000001, 32'd31,       OPC_R, 3'b001, 7'h00, 12'h000, 32'h80000000, 1'b0, 32, 9};
    v[1] = '{"srai31",  32'h80000000, 32'd0,        OPC_I, 3'b101, 7'h00, 12'h41F, 32'hFFFFFFFF, 1'b0, 32, 9};
    v[2] = '{"srli31",  32'h80000000, 32'd0,        OPC_I, 3'b101, 7'h00, 12'h01F, 32'h00000001, 1'b0, 32, 9};
    v[3] = '{"sra6",    32'hF0000000, 32'd6,        OPC_R, 3'b101, 7'h20, 12'h000, 32'hFFC00000, 1'b0, 7, 3};
    v[4] = '{"slli4",   32'h12345678, 32'd0,        OPC_I, 3'b001, 7'h00, 12'h004, 32'h23456780, 1'b0, 5, 2};
    v[5] = '{"srl5_hi", 32'h80000000, 32'hFFFFFFE5, OPC_R, 3'b101, 7'h00, 12'h000, 32'h04000000, 1'b0, 6, 3};
    v[6] = '{"srli8",   32'hF0000000, 32'd0,        OPC_I, 3'b101, 7'h00, 12'h008, 32'h00F00000, 1'b0, 9, 3};
    foreach (v[k]) begin
      do_op(v[k].a, v[k].b, v[k].opc, v[k].f3, v[k].f7, v[k].im, r1, r4, i1, i4, l1, l4);
      n_tests++;
      if (r1 !== v[k].res || i1 !== v[k].ill || l1 != v[k].lat1) begin
        n_fail++;
        $display("FAIL %s_s1: result=%h illegal=%b latency=%0d, want %h %b %0d", v[k].name, r1, i1, l1, v[k].res, v[k].ill, v[k].lat1);
      end
      n_tests++;
      if (r4 !== v[k].res || i4 !== v[k].ill || l4 != v[k].lat4) begin
        n_fail++;
        $display("FAIL %s_s4: result=%h illegal=%b latency=%0d, want %h %b %0d", v[k].name, r4, i4, l4, v[k].res, v[k].ill, v[k].lat4);
      end
    end
  endtask

  task automatic test_zero_and_illegal();
    vec_t v[8];
    logic [31:0] r1, r4; logic i1, i4; int l1, l4;
    v[0] = '{"srl0",      32'hDEADBEEF, 32'd0,  OPC_R, 3'b101, 7'h00, 12'h000, 32'hDEADBEEF, 1'b0, 1, 1};
    v[1] = '{"sll32wrap", 32'hDEADBEEF, 32'h20, OPC_R, 3'b001, 7'h00, 12'h000, 32'hDEADBEEF, 1'b0, 1, 1};
    v[2] = '{"f7_01",     32'hDEADBEEF, 32'd5,  OPC_R, 3'b001, 7'h01, 12'h000, 32'h00000000, 1'b1, 1, 1};
    v[3] = '{"f3_add",    32'hDEADBEEF, 32'd5,  OPC_R, 3'b000, 7'h00, 12'h000, 32'h00000000, 1'b1, 1, 1};
    v[4] = '{"opc_lui",   32'hDEADBEEF, 32'd5,  7'b0110111, 3'b001, 7'h00, 12'h005, 32'h00000000, 1'b1, 1, 1};
    v[5] = '{"slli_imm10",32'hDEADBEEF, 32'd0,  OPC_I, 3'b001, 7'h00, 12'h41F, 32'h00000000, 1'b1, 1, 1};
    v[6] = '{"sra_f3left",32'hDEADBEEF, 32'd3,  OPC_R, 3'b001, 7'h20, 12'h000, 32'h00000000, 1'b1, 1, 1};
    v[7] = '{"srli_imm5", 32'hDEADBEEF, 32'd0,  OPC_I, 3'b101, 7'h00, 12'h020, 32'h00000000, 1'b1, 1, 1};
    foreach (v[k]) begin
      do_op(v[k].a, v[k].b, v[k].opc, v[k].f3, v[k].f7, v[k].im, r1, r4, i1, i4, l1, l4);
      n_tests++;
      if (r1 !== v[k].res || i1 !== v[k].ill || l1 != v[k].lat1) begin
        n_fail++;
        $display("FAIL %s_s1: result=%h illegal=%b latency=%0d, want %h %b %0d", v[k].name, r1, i1, l1, v[k].res, v[k].ill, v[k].lat1);
      end
      n_tests++;
      if (r4 !== v[k].res || i4 !== v[k].ill || l4 != v[k].lat4) begin
        n_fail++;
        $display("FAIL %s_s4: result=%h illegal=%b latency=%0d, want %h %b %0d", v[k].name, r4, i4, l4, v[k].res, v[k].ill, v[k].lat4);
      end
    end
  endtask

  task automatic test_rotate();
    vec_t v[4];
    logic [31:0] r1, r4; logic i1, i4; int l1, l4;
`ifdef SHIFT_ROTATE_EN
    v[0] = '{"ror1",  32'h00000001, 32'd1,  OPC_R, 3'b101, 7'h30, 12'h000, 32'h80000000, 1'b0, 2, 2};
    v[1] = '{"rol4",  32'h80000001, 32'd4,  OPC_R, 3'b001, 7'h30, 12'h000, 32'h00000018, 1'b0, 5, 2};
    v[2] = '{"rori8", 32'h000000FF, 32'd0,  OPC_I, 3'b101, 7'h00, 12'h608, 32'hFF000000, 1'b0, 9, 3};
    v[3] = '{"ror16", 32'h12345678, 32'd16, OPC_R, 3'b101, 7'h30, 12'h000, 32'h56781234, 1'b0, 17, 5};
`else
    v[0] = '{"ror1",  32'h00000001, 32'd1,  OPC_R, 3'b101, 7'h30, 12'h000, 32'h00000000, 1'b1, 1, 1};
    v[1] = '{"rol4",  32'h80000001, 32'd4,  OPC_R, 3'b001, 7'h30, 12'h000, 32'h00000000, 1'b1, 1, 1};
    v[2] = '{"rori8", 32'h000000FF, 32'd0,  OPC_I, 3'b101, 7'h00, 12'h608, 32'h00000000, 1'b1, 1, 1};
    v[3] = '{"ror16", 32'h12345678, 32'd16, OPC_R, 3'b101, 7'h30, 12'h000, 32'h00000000, 1'b1, 1, 1};
`endif
    foreach (v[k]) begin
      do_op(v[k].a, v[k].b, v[k].opc, v[k].f3, v[k].f7, v[k].im, r1, r4, i1, i4, l1, l4);
      n_tests++;
      if (r1 !== v[k].res || i1 !== v[k].ill || l1 != v[k].lat1) begin
        n_fail++;
        $display("FAIL %s_s1: result=%h illegal=%b latency=%0d, want %h %b %0d", v[k].name, r1, i1, l1, v[k].res, v[k].ill, v[k].lat1);
      end
      n_tests++;
      if (r4 !== v[k].res || i4 !== v[k].ill || l4 != v[k].lat4) begin
        n_fail++;
        $display("FAIL %s_s4: result=%h illegal=%b latency=%0d, want %h %b %0d", v[k].name, r4, i4, l4, v[k].res, v[k].ill, v[k].lat4);
      end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    op1 = 32'h3; op2 = 32'd2; opcode = OPC_R; func3 = 3'b001; func7 = 7'h00; imm = '0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    for (int c = 0; c < 50 && !(if1.out_valid === 1'b1 && if4.out_valid === 1'b1); c++) begin
      @(posedge clk); #1;
    end
    n_tests++;
    if (if1.out_valid !== 1'b1 || if4.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_reach_done: out_valid s1=%b s4=%b, want 1 1", if1.out_valid, if4.out_valid);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); op1 = 32'h100 + c; op2 = 32'd0; in_valid = (c % 2 == 0);
      @(posedge clk); #1;
      n_tests++;
      if (if1.result !== 32'hC || if4.result !== 32'hC || if1.in_ready !== 1'b0 || if4.in_ready !== 1'b0 ||
          if1.out_valid !== 1'b1 || if4.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: result=%h/%h in_ready=%b/%b out_valid=%b/%b, want 0000000c 0 1",
                 c, if1.result, if4.result, if1.in_ready, if4.in_ready, if1.out_valid, if4.out_valid);
      end
    end
    @(negedge clk); op1 = 32'h5; op2 = 32'd0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    n_tests++;
    if (if1.in_ready !== 1'b1 || if4.in_ready !== 1'b1 || if1.out_valid !== 1'b0 || if4.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_after_handshake: in_ready=%b/%b out_valid=%b/%b, want 1 0",
               if1.in_ready, if4.in_ready, if1.out_valid, if4.out_valid);
    end
    @(posedge clk); #1; in_valid = 1'b0;
    n_tests++;
    if (if1.out_valid !== 1'b1 || if4.out_valid !== 1'b1 || if1.result !== 32'h5 || if4.result !== 32'h5) begin
      n_fail++;
      $display("FAIL bp_next_accept: out_valid=%b/%b result=%h/%h, want 1 00000005",
               if1.out_valid, if4.out_valid, if1.result, if4.result);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_flush();
    bit seen = 1'b0;
    @(negedge clk);
    op1 = 32'h1; op2 = 32'd31; opcode = OPC_R; func3 = 3'b001; func7 = 7'h00; imm = '0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    n_tests++;
    if (if1.out_valid !== 1'b0 || if4.out_valid !== 1'b0 || if1.in_ready !== 1'b1 || if4.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_to_idle: out_valid=%b/%b in_ready=%b/%b, want 0 1",
               if1.out_valid, if4.out_valid, if1.in_ready, if4.in_ready);
    end
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (if1.out_valid !== 1'b0 || if4.out_valid !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin n_fail++; $display("FAIL flush_no_result: out_valid seen=1, want 0"); end
    @(negedge clk);
    op1 = 32'h9; op2 = 32'd0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
    n_tests++;
    if (if1.out_valid !== 1'b0 || if4.out_valid !== 1'b0 || if1.in_ready !== 1'b1 || if4.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_blocks_accept: out_valid=%b/%b in_ready=%b/%b, want 0 1",
               if1.out_valid, if4.out_valid, if1.in_ready, if4.in_ready);
    end
  endtask

  task automatic test_reset_in_done();
    @(negedge clk);
    op1 = 32'hA; op2 = 32'd1; opcode = OPC_R; func3 = 3'b001; func7 = 7'h00; imm = '0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    for (int c = 0; c < 50 && !(if1.out_valid === 1'b1 && if4.out_valid === 1'b1); c++) begin
      @(posedge clk); #1;
    end
    n_tests++;
    if (if1.out_valid !== 1'b1 || if4.out_valid !== 1'b1 || if1.result !== 32'h14 || if4.result !== 32'h14) begin
      n_fail++;
      $display("FAIL rst_pre_done: out_valid=%b/%b result=%h/%h, want 1 00000014",
               if1.out_valid, if4.out_valid, if1.result, if4.result);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    n_tests++;
    if (if1.out_valid !== 1'b0 || if4.out_valid !== 1'b0 || if1.result !== 32'h0 || if4.result !== 32'h0 ||
        if1.in_ready !== 1'b1 || if4.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_in_done: out_valid=%b/%b result=%h/%h in_ready=%b/%b, want 0 00000000 1",
               if1.out_valid, if4.out_valid, if1.result, if4.result, if1.in_ready, if4.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int v1 = 0;
    int v4 = 0;
    @(negedge clk);
    op1 = 32'h77; op2 = 32'd0; opcode = OPC_R; func3 = 3'b001; func7 = 7'h00; imm = '0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (if1.out_valid === 1'b1) v1++;
      if (if4.out_valid === 1'b1) v4++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_tests++;
    if (v1 != 5 || v4 != 5) begin
      n_fail++; $display("FAIL back_to_back: completions s1=%0d s4=%0d in 10 cycles, want 5 5", v1, v4);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_shift_modes();
    test_zero_and_illegal();
    test_rotate();
    test_backpressure();
    test_flush();
    test_reset_in_done();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_unit_seq.md
# shift_unit_seq

Parametrised multi-cycle shift unit for the execute stage, serving RV32/RV64 SLL/SRL/SRA in both R-type and I-type forms. Accepts one operation at a time over a valid/ready handshake. Shifts STEP bit positions per cycle under a small FSM and holds the result until the consumer takes it. Trades latency for area against the single-cycle shift ALU, and supports pipeline flush.

## Interface
- XLEN, 32, datapath width; 32 or 64.
- STEP, 1, bit positions shifted per SHIFT cycle; power of two, 1..XLEN.
- SHAMT_W (localparam), $clog2(XLEN), shift-amount width.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous abort of the in-flight operation.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept; high only in IDLE.
- op1  in  XLEN  value to shift (rs1).
- op2  in  XLEN  rs2; R-type shift amount = op2[SHAMT_W-1:0].
- opcode  in  7  instruction[6:0]; 0110011 R-type, 0010011 I-type.
- func3  in  3  001 left, 101 right.
- func7  in  7  R-type instruction[31:25].
- imm  in  12  I-type immediate; shift amount = imm[SHAMT_W-1:0].
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  shifted value.
- illegal  out  1  the completed request was not a legal shift encoding.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid, latch op1, the decoded mode, and the shift amount into rem. Go to SHIFT if rem!=0, else DONE.
- Decode, R-type: func7=0000000 with func3 001 gives SLL, with 101 gives SRL; func7=0100000 with 101 gives SRA.
- Decode, I-type: imm[11:SHAMT_W] all zero gives SLLI (001) or SRLI (101). imm[10]=1 with the other upper bits zero and func3 101 gives SRAI.
- Any other opcode/func3/func7/imm combination is illegal. It is accepted, goes straight to DONE with result=0 and illegal=1.
- SHIFT: each cycle shifts by n=min(rem,STEP) and sets rem-=n. Left and logical-right fill with 0; arithmetic-right fills with the latched op1[XLEN-1]. Go to DONE when rem reaches 0.
- DONE: out_valid=1; result and illegal are held stable. On out_ready, go to IDLE.
- No accept in the same cycle as the DONE handshake; in_ready rises the cycle after.
- flush: from SHIFT or DONE, go to IDLE next edge and discard the result. A flush in IDLE blocks acceptance that cycle.
- Priority: rst > flush > handshake/step.
- Shift amount is always taken modulo XLEN, via the SHAMT_W low bits. Upper op2 bits are ignored.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, result=0, illegal=0, rem=0.
- Latency from the accepting edge to out_valid high: 1 + ceil(shamt/STEP) cycles.
- shamt=0 or illegal: latency 1.
- Throughput: one operation per latency + 1 cycles, with out_ready held high.
- rst asserted mid-operation: next edge returns to reset values; in-flight work is lost.
- in_valid while not IDLE: ignored; no input is sampled.
- result is a registered output; no combinational path from inputs to result or out_valid.

## Configuration
- SHIFT_ROTATE_EN defined:
  - R-type func7=0110000 is ROL for func3 001 and ROR for 101.
  - I-type RORI is func3 101 with imm[11:SHAMT_W] = 0110000 (XLEN=32) or 011000 (XLEN=64).
  - Rotate bits wrap around during each SHIFT step, with the same latency rules as shifts.
- Not defined: those encodings decode as illegal (result=0, illegal=1), and no rotate logic is synthesised.

## Test plan
- XLEN=32, STEP=1, R-type SLL, op1=0x00000001, op2=31: result=0x80000000, illegal=0, out_valid 32 cycles after accept.
- STEP=4, SRAI, op1=0x80000000, imm=0x41F: result=0xFFFFFFFF after 9 cycles. SRLI with the same op1 and imm=0x01F: result=0x00000001.
- shamt=0 SRL, op1=0xDEADBEEF: result=0xDEADBEEF after 1 cycle. R-type func7=0000001: result=0, illegal=1 after 1 cycle.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid:
  - result stays stable and in_ready stays 0;
  - no new accept happens;
  - after the handshake, in_ready=1 on the next cycle.
- flush at cycle 3 of a 31-bit STEP=1 shift: out_valid never asserts and the unit is IDLE next cycle. rst asserted in DONE: out_valid=0 and result=0 next cycle.
- SHIFT_ROTATE_EN defined, ROR, op1=0x00000001, op2=1: result=0x80000000. Without the macro, the same request gives illegal=1.
